doc_safety_payload_compare: RTL

Downstream consumer of the FPGA safety payload in the drive-on-chip safety channel. Captures each FPGA payload (speed, over-speed flag, sequence number) and the matching HPS-computed payload, then cross-compares them within a speed tolerance. It counts consecutive disagreements and missing partners, and latches a safe-state request once the consecutive-fault limit is reached. Its outputs feed the safety output/STO logic and diagnostic status registers.

---
 rtl/doc_safety_payload_compare_pkg.sv | 46 ++++
 rtl/doc_safety_payload_compare_if.sv | 26 ++
 rtl/doc_safety_payload_compare_timeout.sv | 30 +++
 rtl/doc_safety_payload_compare.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/doc_safety_payload_compare_pkg.sv
// Shared types, defaults and the speed-tolerance helper for the FPGA/HPS safety payload cross-compare.
package doc_safety_payload_compare_pkg;

  typedef logic [15:0] t_speed;
  typedef logic [7:0]  t_seq;

  typedef struct packed {
    t_speed speed_rpm;
    logic   overspeed;
    t_seq   seq;
  } t_safety_payload;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    SPEED     = 3'd1,
    OVERSPEED = 3'd2,
    SEQ       = 3'd3,
    TIMEOUT   = 3'd4,
    DUP_FPGA  = 3'd5,
    DUP_HPS   = 3'd6
  } t_cmp_fault;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HPS  = 3'd1,
    ST_WAIT_FPGA = 3'd2,
    ST_COMPARE   = 3'd3,
    ST_FAULT     = 3'd4
  } t_cmp_state;

  localparam int DEF_SPEED_TOL      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 50000;
  localparam int DEF_MAX_MISMATCH   = 3;

  localparam int SPEED_DW = $bits(t_speed) + 1;

  // One extra bit on the difference keeps the full unsigned range representable.
  function automatic logic speed_in_tol(input t_speed a, input t_speed b, input int unsigned tol);
    logic signed [SPEED_DW-1:0] delta;
    logic [SPEED_DW-1:0]        mag;
    delta = $signed({1'b0, a}) - $signed({1'b0, b});
    mag   = delta[SPEED_DW-1] ? $unsigned(-delta) : $unsigned(delta);
    return 32'(mag) <= tol;
  endfunction

endpackage

// File: rtl/doc_safety_payload_compare_if.sv
// Payload strobes in, compare verdict and diagnostic status out.
interface doc_safety_payload_compare_if;
  import doc_safety_payload_compare_pkg::*;

  logic            generate_pulse;
  t_safety_payload fpga_payload;
  t_safety_payload hps_payload;
  logic            hps_valid;

  logic            compare_ok;
  logic            compare_fail;
  t_cmp_fault      fault_code;
  logic [3:0]      consec_mismatch;
  logic [15:0]     total_mismatch;
  logic            safe_state;

  modport master (
    output generate_pulse, fpga_payload, hps_payload, hps_valid,
    input  compare_ok, compare_fail, fault_code, consec_mismatch, total_mismatch, safe_state
  );

  modport slave (
    input  generate_pulse, fpga_payload, hps_payload, hps_valid,
    output compare_ok, compare_fail, fault_code, consec_mismatch, total_mismatch, safe_state
  );
endinterface

// File: rtl/doc_safety_payload_compare_timeout.sv
// Loadable down-counter that parks at zero; expired flags the zero count.
module doc_safety_cmp_timeout #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/doc_safety_payload_compare.sv
// Pairs FPGA and HPS safety payloads, cross-compares them and latches safe state after repeated faults.
// Define DOC_SAFETY_SEQ_CHECK_EN to make a sequence-number disagreement a fault.
module doc_safety_payload_compare
  import doc_safety_payload_compare_pkg::*;
#(
  parameter int SPEED_TOL      = DEF_SPEED_TOL,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_MISMATCH   = DEF_MAX_MISMATCH
) (
  input logic                          clk,
  input logic                          reset_n,
  input logic                          reset_safety_n,
  doc_safety_payload_compare_if.slave  bus
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        LIMIT    = 4'(MAX_MISMATCH);
`ifdef DOC_SAFETY_SEQ_CHECK_EN
  localparam logic SEQ_CHECK = 1'b1;
`else
  localparam logic SEQ_CHECK = 1'b0;
`endif

  // States: IDLE no pair open | WAIT_HPS fpga held | WAIT_FPGA hps held | COMPARE verdict | FAULT latched
  t_cmp_state      state, nxt, arrive_nxt;
  logic            fpga_new;
  t_safety_payload fpga_q, hps_q;
  logic            ok_q, fail_q, safe_q;
  t_cmp_fault      code_q, ev_code, cmp_code;
  logic [3:0]      consec_q, consec_inc;
  logic [15:0]     total_q;
  logic            ev_ok, ev_fault, arrive_load, tmr_load, tmr_enable, tmr_expired;

  always_comb begin
    cmp_code = NONE;
    if (SEQ_CHECK && (fpga_q.seq != hps_q.seq)) begin
      cmp_code = SEQ;
    end else if (fpga_q.overspeed != hps_q.overspeed) begin
      cmp_code = OVERSPEED;
    end else if (!speed_in_tol(fpga_q.speed_rpm, hps_q.speed_rpm, SPEED_TOL)) begin
      cmp_code = SPEED;
    end
  end

  always_comb begin
    nxt         = state;
    ev_ok       = 1'b0;
    ev_fault    = 1'b0;
    ev_code     = NONE;
    tmr_load    = 1'b0;
    arrive_nxt  = ST_IDLE;
    arrive_load = 1'b0;
    case ({fpga_new, bus.hps_valid})
      2'b10:   begin arrive_nxt = ST_WAIT_HPS;  arrive_load = 1'b1; end
      2'b01:   begin arrive_nxt = ST_WAIT_FPGA; arrive_load = 1'b1; end
      2'b11:   arrive_nxt = ST_COMPARE;
      default: arrive_nxt = ST_IDLE;
    endcase
    case (state)
      ST_IDLE: begin
        nxt      = arrive_nxt;
        tmr_load = arrive_load;
      end
      ST_WAIT_HPS: begin
        if (bus.hps_valid) begin
          nxt = ST_COMPARE;
        end else if (fpga_new) begin
          ev_fault = 1'b1; ev_code = DUP_FPGA; tmr_load = 1'b1;
        end else if (tmr_expired) begin
          ev_fault = 1'b1; ev_code = TIMEOUT; nxt = ST_IDLE;
        end
      end
      ST_WAIT_FPGA: begin
        if (fpga_new) begin
          nxt = ST_COMPARE;
        end else if (bus.hps_valid) begin
          ev_fault = 1'b1; ev_code = DUP_HPS; tmr_load = 1'b1;
        end else if (tmr_expired) begin
          ev_fault = 1'b1; ev_code = TIMEOUT; nxt = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (cmp_code == NONE) begin
          ev_ok = 1'b1;
        end else begin
          ev_fault = 1'b1; ev_code = cmp_code;
        end
        nxt      = arrive_nxt;
        tmr_load = arrive_load;
      end
      default: nxt = ST_FAULT;
    endcase
    consec_inc = (consec_q == 4'hF) ? 4'hF : consec_q + 4'd1;
    if (ev_fault && (consec_inc >= LIMIT)) begin
      nxt      = ST_FAULT;
      tmr_load = 1'b0;
    end
  end

  assign tmr_enable = (state == ST_WAIT_HPS) || (state == ST_WAIT_FPGA);

  doc_safety_cmp_timeout #(.WIDTH(TMR_W)) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (!reset_safety_n),
    .load       (tmr_load),
    .load_value (TMR_LOAD),
    .enable     (tmr_enable),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE; fpga_new <= 1'b0; fpga_q <= '0; hps_q <= '0;
      ok_q <= 1'b0; fail_q <= 1'b0; safe_q <= 1'b0; code_q <= NONE;
      consec_q <= '0; total_q <= '0;
    end else if (!reset_safety_n) begin
      state <= ST_IDLE; fpga_new <= 1'b0; fpga_q <= '0; hps_q <= '0;
      ok_q <= 1'b0; fail_q <= 1'b0; safe_q <= 1'b0; code_q <= NONE;
      consec_q <= '0; total_q <= '0;
    end else begin
      fpga_new <= bus.generate_pulse;
      if (fpga_new)      fpga_q <= bus.fpga_payload;
      if (bus.hps_valid) hps_q  <= bus.hps_payload;
      state  <= nxt;
      ok_q   <= ev_ok;
      fail_q <= ev_fault;
      safe_q <= (nxt == ST_FAULT);
      if (ev_fault) begin
        code_q   <= ev_code;
        consec_q <= consec_inc;
        total_q  <= (total_q == 16'hFFFF) ? total_q : total_q + 16'd1;
      end else if (ev_ok) begin
        consec_q <= '0;
      end
    end
  end

  assign bus.compare_ok      = ok_q;
  assign bus.compare_fail    = fail_q;
  assign bus.fault_code      = code_q;
  assign bus.consec_mismatch = consec_q;
  assign bus.total_mismatch  = total_q;
  assign bus.safe_state      = safe_q;

endmodule
